keypad_input_driver: RTL
========================

Name: keypad_input_driver

Overview:
- Receive-side counterpart of the calculator's serial display path.
- Scans a chain of parallel-in/serial-out shift registers (74HC165-style) wired to the keypad.
- Debounces every key across successive scans and queues newly pressed keys.
- Delivers queued keys one at a time as key-index codes over a valid/ready handshake to the calculator core.

Parameters:
- NUM_KEYS, 16, number of keys (bits) in the shift-register chain.
- DEBOUNCE_SCANS, 2, consecutive identical scans after a change before the snapshot is accepted (>=1).
- SCAN_IDLE_CYCLES, 64, idle clk cycles between scans (>=0).
- CODE_WIDTH, $clog2(NUM_KEYS), key-code width (derived).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_sr_data  input  1  serial data from chain (QH); 0 = key pressed (pull-up keys)
- o_sr_clk  output  1  registered shift clock to chain; chain shifts on rising edge
- o_sr_load_n  output  1  registered parallel-load strobe, active low
- o_key_code  output  CODE_WIDTH  index of lowest pending key
- o_key_valid  output  1  a pending key exists
- i_key_ready  input  1  consumer accepts o_key_code this cycle
- o_keys_held  output  NUM_KEYS  current debounced pressed mask (1 = pressed)

Behaviour:
- Reset: rst_n asynchronous, active-low; clock clk.
- Reset values:
  - o_sr_clk=0, o_sr_load_n=1, o_key_valid=0, o_key_code=0, o_keys_held=0.
  - snapshot, last_snapshot, pending all 0; stable_cnt=0.
  - FSM=LOAD.
- o_sr_clk and o_sr_load_n come from flops; clk is never gated or forwarded.
- FSM states: LOAD -> SHIFT -> EVAL -> IDLE -> LOAD.
  - LOAD (1 cycle): o_sr_load_n=0, o_sr_clk=0; bit counter cleared.
  - SHIFT (2*NUM_KEYS cycles), for bit i = 0..NUM_KEYS-1:
    - Phase A: o_sr_clk=0; snapshot[i] <= ~i_sr_data.
    - Phase B: o_sr_clk=1.
    - Bit 0 is the first bit out of the chain. The final rising edge is harmless.
  - EVAL (1 cycle):
    - Debounce and pending update (below); o_sr_clk=0.
    - Go to IDLE, or straight to LOAD if SCAN_IDLE_CYCLES=0.
  - IDLE (SCAN_IDLE_CYCLES cycles): outputs idle (load_n=1, sr_clk=0).
- Scan period = 2 + 2*NUM_KEYS + SCAN_IDLE_CYCLES cycles (98 at defaults).
- Scanning never stalls; it is independent of the handshake.
- Debounce, in EVAL:
  - If snapshot != last_snapshot: last_snapshot<=snapshot, stable_cnt<=0.
  - Else: stable_cnt<=min(stable_cnt+1, DEBOUNCE_SCANS).
  - When the incremented value equals DEBOUNCE_SCANS: debounced<=snapshot and new_press=snapshot & ~debounced.
  - A change first seen in scan n is accepted in the EVAL of scan n+DEBOUNCE_SCANS.
- o_keys_held = debounced.
- Pending queue (a NUM_KEYS-bit mask):
  - o_key_valid = |pending.
  - o_key_code = index of lowest set bit of pending; 0 when empty.
  - Both are combinational from the pending register only, with no path from i_key_ready.
  - Each cycle: pending <= (pending & ~accept_mask) | new_press.
  - accept_mask = one-hot(o_key_code) when o_key_valid && i_key_ready, else 0.
  - If accept and new press hit the same bit in the same cycle, the set wins.
- Rules:
  - A held key produces exactly one event (no auto-repeat). Releases produce no event.
  - A key re-pressed after a debounced release produces a new event.
  - Once valid is raised, o_key_code changes only after a handshake, or when a lower-index key is added to pending (allowed).
  - i_key_ready with o_key_valid=0 is ignored.
- Reset mid-operation (any state): all state returns to reset values immediately; the first scan restarts at LOAD after rst_n deasserts.

Test Plan:
- Defaults except DEBOUNCE_SCANS=2, SCAN_IDLE_CYCLES=0 (period 34). Key 5 pressed from scan 1, i_key_ready=1 -> o_key_valid=1, o_key_code=5 for exactly one cycle, in the cycle after EVAL of scan 3. o_keys_held=0x0020.
- Waveform check: one scan -> load_n low exactly 1 cycle, then 16 rising edges of o_sr_clk spaced 2 cycles apart. i_sr_data sampled while o_sr_clk=0.
- Bounce: key 3 toggles every scan for 10 scans -> o_key_valid stays 0, o_keys_held stays 0. Key then held steady -> one event with code 3 after 2 further scans.
- Keys 2 and 9 pressed in the same scan, ready=0 -> valid=1, code=2 held stable. Pulse ready 1 cycle -> next cycle code=9. Pulse again -> valid=0.
- Key 7 held 20 scans, ready=1 -> exactly one handshake. Release (debounced), re-press -> second handshake with code 7.
- Reset asserted mid-SHIFT with pending=0x0104 -> same cycle o_key_valid=0, o_sr_clk=0, o_sr_load_n=1, o_keys_held=0. After release, first scan restarts at LOAD.

Source files
------------

// File: rtl/keypad_input_driver.sv
// Keypad scanner for a 74HC165-style PISO chain: debounces all keys across scans
// and queues new presses, delivering them as key indices over valid/ready.
module keypad_input_driver #(
    parameter int NUM_KEYS         = 16,
    parameter int DEBOUNCE_SCANS   = 2,
    parameter int SCAN_IDLE_CYCLES = 64,
    parameter int CODE_WIDTH       = $clog2(NUM_KEYS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_sr_data,
    output logic                  o_sr_clk,
    output logic                  o_sr_load_n,
    output logic [CODE_WIDTH-1:0] o_key_code,
    output logic                  o_key_valid,
    input  logic                  i_key_ready,
    output logic [NUM_KEYS-1:0]   o_keys_held
);

    localparam int BIT_W       = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int CNT_W       = $clog2(DEBOUNCE_SCANS + 1);
    localparam int IDLE_W      = (SCAN_IDLE_CYCLES > 1) ? $clog2(SCAN_IDLE_CYCLES) : 1;
    localparam int IDLE_LAST_I = (SCAN_IDLE_CYCLES > 0) ? SCAN_IDLE_CYCLES - 1 : 0;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0]  DB_MAX    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LAST_I);

    typedef enum logic [1:0] {
        S_LOAD,
        S_SHIFT,
        S_EVAL,
        S_IDLE
    } state_t;

    state_t              state;
    logic [BIT_W-1:0]    bit_idx;
    logic                phase_b;
    logic [IDLE_W-1:0]   idle_cnt;
    logic [NUM_KEYS-1:0] snapshot;
    logic [NUM_KEYS-1:0] last_snapshot;
    logic [NUM_KEYS-1:0] debounced;
    logic [CNT_W-1:0]    stable_cnt;
    logic [NUM_KEYS-1:0] pending;
    logic                sr_clk_q;
    logic                load_n_q;

    logic                snap_same;
    logic [CNT_W-1:0]    cnt_inc;
    logic                accept_now;
    logic [NUM_KEYS-1:0] new_press;
    logic [CODE_WIDTH-1:0] low_code;
    logic                low_found;
    logic [NUM_KEYS-1:0] accept_mask;

    // Debounce decision, evaluated only while the FSM sits in EVAL.
    always_comb begin
        snap_same  = (snapshot == last_snapshot);
        cnt_inc    = (stable_cnt == DB_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
        accept_now = (state == S_EVAL) && snap_same && (cnt_inc == DB_MAX);
        new_press  = accept_now ? (snapshot & ~debounced) : '0;
    end

    always_comb begin
        low_code  = '0;
        low_found = 1'b0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (pending[i] && !low_found) begin
                low_code  = CODE_WIDTH'(i);
                low_found = 1'b1;
            end
        end
    end

    always_comb begin
        accept_mask = '0;
        if (low_found && i_key_ready)
            accept_mask = NUM_KEYS'(1) << low_code;
    end

    // The pin flops take the value chosen in the current phase, so each pin lags
    // the state by one cycle: load_n is low during the first SHIFT cycle, and the
    // data bit is captured in the second (phase B) cycle while the pin is still low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_LOAD;
            bit_idx       <= '0;
            phase_b       <= 1'b0;
            idle_cnt      <= '0;
            snapshot      <= '0;
            last_snapshot <= '0;
            debounced     <= '0;
            stable_cnt    <= '0;
            sr_clk_q      <= 1'b0;
            load_n_q      <= 1'b1;
        end else begin
            case (state)
                S_LOAD: begin
                    load_n_q <= 1'b0;
                    sr_clk_q <= 1'b0;
                    bit_idx  <= '0;
                    phase_b  <= 1'b0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (!phase_b) begin
                        load_n_q <= 1'b1;
                        sr_clk_q <= 1'b0;
                        phase_b  <= 1'b1;
                    end else begin
                        snapshot[bit_idx] <= ~i_sr_data;
                        sr_clk_q          <= 1'b1;
                        phase_b           <= 1'b0;
                        if (bit_idx == LAST_BIT)
                            state <= S_EVAL;
                        else
                            bit_idx <= bit_idx + BIT_W'(1);
                    end
                end
                S_EVAL: begin
                    sr_clk_q <= 1'b0;
                    load_n_q <= 1'b1;
                    if (!snap_same) begin
                        last_snapshot <= snapshot;
                        stable_cnt    <= '0;
                    end else begin
                        stable_cnt <= cnt_inc;
                        if (cnt_inc == DB_MAX)
                            debounced <= snapshot;
                    end
                    idle_cnt <= '0;
                    state    <= (SCAN_IDLE_CYCLES == 0) ? S_LOAD : S_IDLE;
                end
                S_IDLE: begin
                    sr_clk_q <= 1'b0;
                    load_n_q <= 1'b1;
                    if (idle_cnt == IDLE_LAST)
                        state <= S_LOAD;
                    else
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    // A new press on the bit being accepted in the same cycle keeps it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pending <= '0;
        else
            pending <= (pending & ~accept_mask) | new_press;
    end

    assign o_sr_clk    = sr_clk_q;
    assign o_sr_load_n = load_n_q;
    assign o_key_valid = low_found;
    assign o_key_code  = low_code;
    assign o_keys_held = debounced;

endmodule
